// File: rtl/disp_pkg.sv
// disp_pkg: shared types, scan states and hex-to-segment table for the display scanner.
package disp_pkg;
    typedef logic [6:0] seg7_t;
    localparam seg7_t SEG_BLANK = 7'h7F;
    typedef enum logic [1:0] {IDLE, GUARD, SHOW} scan_state_e;
    // active-low {g,f,e,d,c,b,a} patterns for 0-F
    localparam seg7_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low 7-segment decoder.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);
    assign seg = HEX_SEG[nib];
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: self-timed N-digit 7-segment scanner with guard interval,
// per-frame snapshot and leading-zero blanking; all outputs registered.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DWELL_CYC = 50000,
    parameter int GUARD_CYC = 500,
    parameter int LZ_BLANK  = 1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        blank_lz,
    input  logic [4*N_DIGITS-1:0]       digits,
    input  logic [N_DIGITS-1:0]         dp_in,
    output logic [N_DIGITS-1:0]         anodo,
    output seg7_t                       seg,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_tick
);
    localparam int MAXC = DWELL_CYC > GUARD_CYC ? DWELL_CYC : GUARD_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] DLAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] GLAST = CW'(GUARD_CYC > 0 ? GUARD_CYC - 1 : 0);
    localparam logic [IW-1:0] ILAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE = 1;
    // with no guard the engine steps SHOW to SHOW
    localparam scan_state_e GAP = GUARD_CYC > 0 ? GUARD : SHOW;

    scan_state_e st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic load, z, blank;
    logic [4*N_DIGITS-1:0] snap_d, snap_d_n;
    logic [N_DIGITS-1:0] snap_p, snap_p_n, lz;
    logic [3:0] nib;
    seg7_t dec;

    always_comb begin
        st_n = st;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        load = 1'b0;
        if (!en) begin
            st_n = IDLE;
            cnt_n = '0;
            idx_n = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_n = GAP;
                    cnt_n = '0;
                    idx_n = '0;
                    load = 1'b1;
                end
                GUARD: if (cnt == GLAST) begin
                    st_n = SHOW;
                    cnt_n = '0;
                end
                default: if (cnt == DLAST) begin
                    st_n = GAP;
                    cnt_n = '0;
                    idx_n = idx == ILAST ? '0 : idx + 1'b1;
                    load = idx == ILAST;
                end
            endcase
        end
    end

    // decode looks at the snapshot as it will be after this edge
    assign snap_d_n = load ? digits : snap_d;
    assign snap_p_n = load ? dp_in : snap_p;
    assign nib = snap_d_n[{idx_n, 2'b00} +: 4];

    // lz[i] is set when nibbles i..N-1 are all zero
    always_comb begin
        z = 1'b1;
        lz = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            z = z & (snap_d_n[4*i +: 4] == 4'h0);
            lz[i] = z;
        end
    end

    assign blank = (LZ_BLANK != 0) && blank_lz && (idx_n != '0) && lz[idx_n];
    assign digit_idx = idx;

    hex7seg u_dec (.nib(nib), .seg(dec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
            idx <= '0;
            snap_d <= '0;
            snap_p <= '0;
            anodo <= '1;
            seg <= SEG_BLANK;
            dp <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            idx <= idx_n;
            snap_d <= snap_d_n;
            snap_p <= snap_p_n;
            anodo <= st_n == SHOW ? ~(ONE << idx_n) : '1;
            seg <= (st_n == SHOW && !blank) ? dec : SEG_BLANK;
            dp <= !(st_n == SHOW && snap_p_n[idx_n]);
            frame_tick <= load;
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for two scanner configurations
// (N=4/G=2/D=4 and N=8/G=0/D=4) against a frame-position reference model.
module tb_disp_scan_ctrl;
    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       tick;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 0, rst = 1, en = 0, blz = 0;
    logic [15:0] dig1 = '0;
    logic [3:0] dp1 = '0;
    logic [31:0] dig2 = '0;
    logic [7:0] dp2 = '0;
    logic [3:0] an1;
    logic [6:0] seg1, seg2;
    logic dpo1, dpo2, tick1, tick2;
    logic [1:0] idx1;
    logic [7:0] an2;
    logic [2:0] idx2;

    int errors = 0, checks = 0;
    int t1 = -1, t2 = -1;
    logic [31:0] s1 = '0, s2 = '0;
    logic [7:0] p1 = '0, p2 = '0;
    exp_t q1[$], q2[$];

    always #5 clk = ~clk;

    disp_scan_ctrl #(.N_DIGITS(4), .DWELL_CYC(4), .GUARD_CYC(2), .LZ_BLANK(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blz), .digits(dig1), .dp_in(dp1),
        .anodo(an1), .seg(seg1), .dp(dpo1), .digit_idx(idx1), .frame_tick(tick1)
    );

    disp_scan_ctrl #(.N_DIGITS(8), .DWELL_CYC(4), .GUARD_CYC(0), .LZ_BLANK(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blz), .digits(dig2), .dp_in(dp2),
        .anodo(an2), .seg(seg2), .dp(dpo2), .digit_idx(idx2), .frame_tick(tick2)
    );

    // t = cycles since leaving IDLE; everything follows from frame position
    function automatic exp_t model(int n, int g, int d, int t, logic [31:0] sd, logic [7:0] sp, logic bl);
        exp_t e;
        int per, pos, dg;
        e.an = 8'((1 << n) - 1);
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.idx = 3'd0;
        e.tick = 1'b0;
        if (t < 0) return e;
        per = g + d;
        pos = t % (n * per);
        dg = pos / per;
        e.idx = 3'(dg);
        e.tick = pos == 0;
        if (pos % per >= g) begin
            e.an[dg] = 1'b0;
            e.dp = ~sp[dg];
            e.seg = (bl && dg != 0 && (sd >> (4 * dg)) == 0) ? 7'h7F : HEX[sd[4*dg +: 4]];
        end
        return e;
    endfunction

    task automatic check(string nm, exp_t act, exp_t ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s @%0t got an=%h seg=%h dp=%b idx=%0d tick=%b want an=%h seg=%h dp=%b idx=%0d tick=%b",
                     nm, $time, act.an, act.seg, act.dp, act.idx, act.tick, ex.an, ex.seg, ex.dp, ex.idx, ex.tick);
        end
    endtask

    always begin
        @(posedge clk);
        if (rst) begin
            t1 = -1;
            t2 = -1;
        end else begin
            t1 = en ? t1 + 1 : -1;
            t2 = en ? t2 + 1 : -1;
        end
        if (t1 >= 0 && t1 % 24 == 0) begin
            s1 = {16'h0, dig1};
            p1 = {4'h0, dp1};
        end
        if (t2 >= 0 && t2 % 32 == 0) begin
            s2 = dig2;
            p2 = dp2;
        end
        q1.push_back(model(4, 2, 4, t1, s1, p1, blz));
        q2.push_back(model(8, 0, 4, t2, s2, p2, blz));
    end

    // an asynchronous reset darkens the response already queued for this cycle
    always begin
        @(posedge rst);
        if (q1.size() > 0) begin
            void'(q1.pop_back());
            q1.push_back(model(4, 2, 4, -1, '0, '0, 1'b0));
        end
        if (q2.size() > 0) begin
            void'(q2.pop_back());
            q2.push_back(model(8, 0, 4, -1, '0, '0, 1'b0));
        end
    end

    always begin : mon
        exp_t e;
        @(negedge clk);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1", {4'h0, an1, seg1, dpo1, 1'b0, idx1, tick1}, e);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("dut2", {an2, seg2, dpo2, idx2, tick2}, e);
        end
        checks++;
        if ($countones(~an2) > 1 || $countones(~an1) > 1) begin
            errors++;
            $display("FAIL overlap @%0t got an1=%b an2=%b want at most one low", $time, an1, an2);
        end
    end

    task automatic wait_an(input logic [3:0] v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an1 == v) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_an timeout got an1=%b want %b", an1, v);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        dig1 = 16'h1234;
        dig2 = 32'h8765_4321;
        en = 1;
        repeat (30) @(negedge clk);
        wait_an(4'b1011);
        dig1 = 16'hABCD;
        dig2 = 32'hFEDC_BA98;
        repeat (40) @(negedge clk);
        blz = 1;
        dig1 = 16'h0050;
        dig2 = 32'h0000_0500;
        repeat (48) @(negedge clk);
        dig1 = 16'h0000;
        dp1 = 4'b1000;
        dig2 = 32'h0;
        dp2 = 8'h81;
        repeat (48) @(negedge clk);
        wait_an(4'b1011);
        en = 0;
        repeat (5) @(negedge clk);
        en = 1;
        repeat (30) @(negedge clk);
        wait_an(4'b1011);
        @(posedge clk);
        #1 rst = 1;
        #1;
        checks++;
        if (an1 !== 4'hF || seg1 !== 7'h7F || dpo1 !== 1'b1 || an2 !== 8'hFF) begin
            errors++;
            $display("FAIL async_rst got an1=%b seg1=%h dp1=%b an2=%b want all dark", an1, seg1, dpo1, an2);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            dig1 = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp1 = 4'($urandom);
            dig2 = $urandom >> (4 * $urandom_range(0, 7));
            dp2 = 8'($urandom);
            blz = 1'($urandom_range(0, 1));
            en = $urandom_range(0, 5) != 0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        en = 1;
        repeat (50) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Parametrised multiplexed 7-segment display scanner. It replaces the externally driven 2-bit anode selector with a self-timed scan engine that:
- owns its own refresh prescaler and generalises to N digits;
- inserts a guard (ghosting) interval between digits;
- snapshots the displayed value once per frame, so no tearing is visible;
- drives the active-low anode and segment pins on the board.

It sits between the binary/Gray conversion datapath and the top-level display pins.

## Interface
- N_DIGITS, 4: number of digits / anodes, 2..8
- DWELL_CYC, 50000: clock cycles each digit is lit, ≥1
- GUARD_CYC, 500: cycles with all anodes off between digits; 0 = no guard
- LZ_BLANK, 1: 1 = leading-zero suppression available (gated by `blank_lz`)

Ports:
- clk  in  1  system clock, the block's only clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; 0 = display dark, engine idle
- blank_lz  in  1  suppress leading zeros (ignored when LZ_BLANK=0)
- digits  in  4*N_DIGITS  hex nibble per digit; [3:0] = digit 0 (rightmost)
- dp_in  in  N_DIGITS  decimal point per digit, 1 = on
- anodo  out  N_DIGITS  anodes, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- digit_idx  out  $clog2(N_DIGITS)  digit currently selected
- frame_tick  out  1  one-cycle pulse at frame start

## Operation
- FSM states:
  - IDLE: all outputs dark.
  - GUARD: anodes all high (off), seg/dp off.
  - SHOW: exactly one anode low, at `digit_idx`.
- Transitions:
  - IDLE→GUARD: when en=1, with idx=0.
  - GUARD→SHOW: after GUARD_CYC cycles.
  - SHOW→GUARD: after DWELL_CYC cycles; idx increments, wrapping N_DIGITS-1→0.
  - If GUARD_CYC=0: SHOW→SHOW directly, with the idx increment.
- en=0 in any state: next edge goes to IDLE, counter=0, idx=0.
- Snapshot register (4*N + N bits):
  - Loads `digits`/`dp_in` on every edge that sets idx to 0, i.e. IDLE exit and wrap.
  - All decode uses the snapshot only.
  - Input changes mid-frame are not visible until the next frame.
- frame_tick fires on the same edge as the snapshot load.
- Leading-zero blanking, applied when blank_lz=1 and LZ_BLANK=1:
  - Digit i (i≥1) is blanked (seg=7'h7F) if snapshot nibbles i..N-1 are all 0.
  - Digit 0 is never blanked.
  - dp is still honoured on blanked digits.
- Hex decode covers 0-F, standard patterns (e.g. 0→7'b1000000, 8→7'b0000000, F→7'b0001110).
- Counter width is $clog2(max(DWELL_CYC,GUARD_CYC)+1). It counts up from 0 and clears on every state change.

## Timing
- All outputs are registered. They change on the same edge as the FSM state/idx they reflect: anodo/seg are valid from the first cycle of SHOW.
- Reset values: anodo all 1, seg=7'h7F, dp=1, digit_idx=0, frame_tick=0, FSM=IDLE, counter=0, snapshot=0.
- Reset mid-frame blanks the outputs asynchronously; scanning restarts from digit 0 with a new snapshot.
- Period per digit: GUARD_CYC+DWELL_CYC cycles. Frame: N_DIGITS × that.
- en rising: first SHOW (digit 0) begins GUARD_CYC+1 edges later. frame_tick is high on the cycle after the IDLE→GUARD edge.
- Anodes are never low for two digits in the same cycle, including across the wrap and GUARD_CYC=0.

## Structure
- Shared package `disp_pkg`:
  - `seg7_t` (logic [6:0]);
  - `SEG_BLANK` = 7'h7F;
  - scan-state enum `scan_state_e` {IDLE, GUARD, SHOW};
  - the hex→segment constant table.
- Sub-module `hex7seg`: a combinational nibble→`seg7_t` decoder, instanced once on the muxed snapshot nibble. The anode/FSM/snapshot logic stays in `disp_scan_ctrl`.

## Test plan
All scenarios use N=4, DWELL=4, GUARD=2, unless stated.
- Reset then en=1, digits=16'h1234:
  - anodo sequence 1111(2)→1110(4)→1111(2)→1101(4)→1111(2)→1011(4)→…
  - seg shows 4,3,2,1 in that order;
  - frame_tick once per 24 cycles.
- Change digits to 16'hABCD during digit 2:
  - the current frame still shows 1234;
  - the next frame shows D,C,B,A;
  - frame_tick aligns with the switch.
- blank_lz=1, digits=16'h0050:
  - digits 3 and 2 give seg=7'h7F with the anode still scanning;
  - digits 1 and 0 show 5 and 0.
- blank_lz=1, digits=16'h0000:
  - only digit 0 shows 0;
  - dp_in=4'b1000 gives dp=0 on blanked digit 3.
- GUARD=0 and N=8: anodo steps one-hot-low every 4 cycles, wraps 7→0, and never has two zeros in one cycle.
- Assert rst (or drop en) mid-SHOW on digit 2:
  - outputs go dark immediately (next edge for en);
  - on restart, the first lit digit is 0.
